// File: rtl/mem_pkg.sv
// Shared types for the data-memory responder: FSM encoding, op codes, widths.
package mem_pkg;

  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned BUS_ADDR_W = 16;
  localparam int unsigned CNT_W      = 4;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BUSY    = 2'd1,
    S_RESP    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OP_RD  = 2'd0,
    OP_WR  = 2'd1,
    OP_BAD = 2'd2
  } op_t;

  // Only meaningful while at least one strobe is high.
  function automatic op_t decode_op(input logic rd, input logic wr, input logic oor);
    if ((rd && wr) || oor) return OP_BAD;
    else if (wr)           return OP_WR;
    else                   return OP_RD;
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Core-to-data-memory strobe/response bus.
interface data_mem_responder_if
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
) ();

  logic                  mem_rd;
  logic                  mem_wr;
  logic [BUS_ADDR_W-1:0] addr;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W-1:0]     rdata;
  logic                  ready;
  logic                  err;

  modport master (output mem_rd, mem_wr, addr, wdata, input rdata, ready, err);
  modport slave  (input mem_rd, mem_wr, addr, wdata, output rdata, ready, err);

endinterface

// File: rtl/data_mem_responder_mem_array.sv
// Word array with a synchronous write port and an asynchronous read port; never cleared.
module mem_array #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wd,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rd_c
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wd;
  end

  assign o_rd_c = r_mem[i_raddr];

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory slave for the multicycle Core: latches a strobe, waits LATENCY cycles,
// then commits/reads the array and pulses ready (with err for illegal requests).
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned LATENCY = 2
) (
  input logic                 clk,
  input logic                 reset,
  data_mem_responder_if.slave bus
);

  localparam logic [CNT_W-1:0] LAT_M1 = (LATENCY > 0) ? CNT_W'(LATENCY - 1) : '0;

  state_t            r_state, w_next;
  logic [CNT_W-1:0]  r_cnt, w_cnt_next;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  op_t               r_op;
  logic [DATA_W-1:0] r_rdata;
  logic              r_ready;
  logic              r_err;

  logic              w_req;
  logic              w_oor;
  op_t               w_op_in;
  op_t               w_op_eff;
  logic [ADDR_W-1:0] w_addr_eff;
  logic [DATA_W-1:0] w_wdata_eff;
  logic              w_enter_resp;
  logic              w_we;
  logic [DATA_W-1:0] w_rd_data;

  assign w_req   = bus.mem_rd | bus.mem_wr;
  assign w_oor   = (bus.addr >> ADDR_W) != '0;
  assign w_op_in = decode_op(bus.mem_rd, bus.mem_wr, w_oor);

  // With LATENCY=0 the response edge is the acceptance edge, so use live inputs in IDLE.
  assign w_op_eff    = (r_state == S_IDLE) ? w_op_in : r_op;
  assign w_addr_eff  = (r_state == S_IDLE) ? bus.addr[ADDR_W-1:0] : r_addr;
  assign w_wdata_eff = (r_state == S_IDLE) ? bus.wdata : r_wdata;

  always_comb begin
    w_next       = r_state;
    w_cnt_next   = r_cnt;
    w_enter_resp = 1'b0;
    w_we         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          if (LATENCY == 0) begin
            w_next = S_RESP;
          end else begin
            w_next     = S_BUSY;
            w_cnt_next = LAT_M1;
          end
        end
      end
      S_BUSY: begin
        if (r_cnt == '0) w_next = S_RESP;
        else             w_cnt_next = r_cnt - 1'b1;
      end
      S_RESP:    w_next = S_RELEASE;
      S_RELEASE: if (!w_req) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
    w_enter_resp = (w_next == S_RESP);
    // Reset outranks a write landing on the same edge.
    w_we = w_enter_resp && (w_op_eff == OP_WR) && !reset;
  end

  mem_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem_array (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_addr_eff),
    .i_wd    (w_wdata_eff),
    .i_raddr (w_addr_eff),
    .o_rd_c  (w_rd_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_op    <= OP_RD;
      r_rdata <= '0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (r_state == S_IDLE && w_req) begin
        r_addr  <= bus.addr[ADDR_W-1:0];
        r_wdata <= bus.wdata;
        r_op    <= w_op_in;
      end
      r_ready <= w_enter_resp;
      r_err   <= w_enter_resp && (w_op_eff == OP_BAD);
      // rdata only moves on a read response or an error response.
      if (w_enter_resp) begin
        if (w_op_eff == OP_RD)       r_rdata <= w_rd_data;
        else if (w_op_eff == OP_BAD) r_rdata <= '0;
      end
    end
  end

  assign bus.rdata = r_rdata;
  assign bus.ready = r_ready;
  assign bus.err   = r_err;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: three responders (LATENCY 2, 0, 4) share one stimulus port, selected by sel.
module tb_data_mem_responder;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_all = 1'b1;
  logic        rst_one = 1'b0;
  int          sel = 0;
  logic        tb_rd = 1'b0;
  logic        tb_wr = 1'b0;
  logic [15:0] tb_addr = '0;
  logic [15:0] tb_wdata = '0;
  logic [15:0] o_rdata;
  logic        o_ready;
  logic        o_err;
  logic        rst0, rst1, rst2;
  int          vec_cnt = 0;
  int          miss_cnt = 0;

  always #5 clk = ~clk;

  data_mem_responder_if #(.DATA_W(16)) if0 ();
  data_mem_responder_if #(.DATA_W(16)) if1 ();
  data_mem_responder_if #(.DATA_W(16)) if2 ();

  assign rst0 = rst_all | (rst_one & (sel == 0));
  assign rst1 = rst_all | (rst_one & (sel == 1));
  assign rst2 = rst_all | (rst_one & (sel == 2));

  assign if0.mem_rd = tb_rd & (sel == 0);
  assign if0.mem_wr = tb_wr & (sel == 0);
  assign if0.addr   = tb_addr;
  assign if0.wdata  = tb_wdata;
  assign if1.mem_rd = tb_rd & (sel == 1);
  assign if1.mem_wr = tb_wr & (sel == 1);
  assign if1.addr   = tb_addr;
  assign if1.wdata  = tb_wdata;
  assign if2.mem_rd = tb_rd & (sel == 2);
  assign if2.mem_wr = tb_wr & (sel == 2);
  assign if2.addr   = tb_addr;
  assign if2.wdata  = tb_wdata;

  always_comb begin
    case (sel)
      1:       begin o_rdata = if1.rdata; o_ready = if1.ready; o_err = if1.err; end
      2:       begin o_rdata = if2.rdata; o_ready = if2.ready; o_err = if2.err; end
      default: begin o_rdata = if0.rdata; o_ready = if0.ready; o_err = if0.err; end
    endcase
  end

  data_mem_responder #(.DATA_W(16), .ADDR_W(8), .LATENCY(2)) u_dut0 (.clk(clk), .reset(rst0), .bus(if0));
  data_mem_responder #(.DATA_W(16), .ADDR_W(8), .LATENCY(0)) u_dut1 (.clk(clk), .reset(rst1), .bus(if1));
  data_mem_responder #(.DATA_W(16), .ADDR_W(8), .LATENCY(4)) u_dut2 (.clk(clk), .reset(rst2), .bus(if2));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One request; optionally alters addr/wdata after acceptance and holds strobes past ready.
  task automatic access(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d,
                        input int lat, input logic exp_err, input logic [15:0] exp_rdata,
                        input int hold, input logic chg);
    int n;
    tb_rd = rd; tb_wr = wr; tb_addr = a; tb_wdata = d;
    step();
    if (chg) begin tb_addr = a + 16'd1; tb_wdata = 16'hFFFF; end
    n = 0;
    while (!o_ready && n < 20) begin step(); n++; end
    chk($sformatf("lat@%0h", a), 32'(n), 32'(lat));
    chk($sformatf("err@%0h", a), 32'(o_err), 32'(exp_err));
    chk($sformatf("rdata@%0h", a), 32'(o_rdata), 32'(exp_rdata));
    for (int i = 0; i <= hold; i++) begin
      step();
      chk($sformatf("ready_drop@%0h", a), 32'(o_ready), 32'd0);
    end
    tb_rd = 1'b0; tb_wr = 1'b0;
    step();
  endtask

  // Write to DUT 2, then reset on the k-th edge after acceptance.
  task automatic reset_mid(input logic [15:0] a, input logic [15:0] d, input int k);
    tb_wr = 1'b1; tb_addr = a; tb_wdata = d;
    step();
    repeat (k - 1) step();
    rst_one = 1'b1; tb_wr = 1'b0;
    step();
    rst_one = 1'b0;
    chk($sformatf("rst%0d_ready", k), 32'(o_ready), 32'd0);
    chk($sformatf("rst%0d_err", k), 32'(o_err), 32'd0);
    chk($sformatf("rst%0d_state", k), 32'(u_dut2.r_state), 32'(S_IDLE));
    step();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_all = 1'b0;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      chk($sformatf("rst_ready%0d", s), 32'(o_ready), 32'd0);
      chk($sformatf("rst_err%0d", s), 32'(o_err), 32'd0);
      chk($sformatf("rst_rdata%0d", s), 32'(o_rdata), 32'd0);
    end
    chk("rst_state0", 32'(u_dut0.r_state), 32'(S_IDLE));

    // LATENCY=2: write then read back, rdata sticks
    sel = 0;
    access(1'b0, 1'b1, 16'h0005, 16'hBEEF, 2, 1'b0, 16'h0000, 0, 1'b0);
    access(1'b1, 1'b0, 16'h0005, 16'h0000, 2, 1'b0, 16'hBEEF, 0, 1'b0);
    repeat (3) step();
    chk("rdata_hold", 32'(o_rdata), 32'h0000BEEF);

    // out-of-range write must not alias onto word 0
    access(1'b0, 1'b1, 16'h0000, 16'h1111, 2, 1'b0, 16'hBEEF, 0, 1'b0);
    access(1'b0, 1'b1, 16'h0100, 16'hAAAA, 2, 1'b1, 16'h0000, 0, 1'b0);
    access(1'b1, 1'b0, 16'h0000, 16'h0000, 2, 1'b0, 16'h1111, 0, 1'b0);
    access(1'b1, 1'b0, 16'h8000, 16'h0000, 2, 1'b1, 16'h0000, 0, 1'b0);

    // both strobes: error, word untouched
    access(1'b0, 1'b1, 16'h0003, 16'h3333, 2, 1'b0, 16'h0000, 0, 1'b0);
    access(1'b1, 1'b1, 16'h0003, 16'hDEAD, 2, 1'b1, 16'h0000, 0, 1'b0);
    access(1'b1, 1'b0, 16'h0003, 16'h0000, 2, 1'b0, 16'h3333, 0, 1'b0);

    // inputs change during BUSY are ignored
    access(1'b0, 1'b1, 16'h000A, 16'h0A0A, 2, 1'b0, 16'h3333, 0, 1'b0);
    access(1'b0, 1'b1, 16'h0009, 16'h0001, 2, 1'b0, 16'h3333, 0, 1'b1);
    access(1'b1, 1'b0, 16'h0009, 16'h0000, 2, 1'b0, 16'h0001, 0, 1'b0);
    access(1'b1, 1'b0, 16'h000A, 16'h0000, 2, 1'b0, 16'h0A0A, 0, 1'b0);

    // LATENCY=0 with a held read strobe
    sel = 1;
    #1;
    access(1'b0, 1'b1, 16'h00FF, 16'h1234, 0, 1'b0, 16'h0000, 0, 1'b0);
    access(1'b1, 1'b0, 16'h00FF, 16'h0000, 0, 1'b0, 16'h1234, 4, 1'b0);
    access(1'b1, 1'b0, 16'h00FF, 16'h0000, 0, 1'b0, 16'h1234, 0, 1'b0);

    // LATENCY=4 with reset mid-BUSY and on the commit edge
    sel = 2;
    #1;
    access(1'b0, 1'b1, 16'h0007, 16'h7777, 4, 1'b0, 16'h0000, 0, 1'b0);
    reset_mid(16'h0007, 16'h5555, 2);
    chk("rst_rdata_clr", 32'(o_rdata), 32'd0);
    reset_mid(16'h0007, 16'h6666, 4);
    access(1'b1, 1'b0, 16'h0007, 16'h0000, 4, 1'b0, 16'h7777, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
